// File: rtl/jtag_scan_master.sv
//==============================================================================
// Module   : jtag_scan_master
// Brief    : System-clock JTAG initiator for TAP reset, IR scans and DR scans.
//            Define JTAG_SCAN_MASTER_TRST_EN to pulse trst_n before TAP reset.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module jtag_scan_master #(
   parameter int CLK_DIV = 9,
   parameter int IR_LEN  = 6,
   parameter int DR_MAX  = 41
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [5:0]        cmd_len,
   input  logic [DR_MAX-1:0] cmd_data,
   output logic              rsp_valid,
   output logic [DR_MAX-1:0] rsp_data,
   output logic              tclk,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo,
   output logic              trst_n
);

`ifdef JTAG_SCAN_MASTER_TRST_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0, RESET_SEQ = 3'd1, HDR = 3'd2, SHIFT = 3'd3, TAIL = 3'd4, TRST = 3'd5
   } state_t;
   localparam state_t c_sync_state = TRST;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0, RESET_SEQ = 3'd1, HDR = 3'd2, SHIFT = 3'd3, TAIL = 3'd4
   } state_t;
   localparam state_t c_sync_state = RESET_SEQ;
`endif

   localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
   localparam logic [5:0] c_ir_len   = 6'(IR_LEN);
   localparam logic [5:0] c_dr_max   = 6'(DR_MAX);
   localparam logic [1:0] c_op_rst   = 2'd0;
   localparam logic [1:0] c_op_ir    = 2'd1;
   localparam logic [1:0] c_op_dr    = 2'd2;
   localparam logic [1:0] c_op_nop   = 2'd3;

   state_t            r_state, w_state_nx, w_start;
   logic [7:0]        r_div;
   logic [5:0]        r_bit, w_bit_nx, w_nbits, r_len, w_len_acc;
   logic              r_scan, r_ir, r_synced, r_ready;
   logic [DR_MAX-1:0] r_data, r_cap, w_data_sh;
   logic              r_tclk, r_tms, r_tdi;
   logic              w_accept, w_tick, w_rise, w_fall, w_last, w_done;
   logic              w_tms_nx, w_tdi_nx;

   assign cmd_ready = r_ready;
   assign tclk      = r_tclk;
   assign tms       = r_tms;
   assign tdi       = r_tdi;

   assign w_accept  = cmd_valid && r_ready;
   assign w_tick    = (r_state != IDLE) && (r_div == c_div_last);
   assign w_rise    = w_tick && !r_tclk;
   assign w_fall    = w_tick && r_tclk;
   assign w_data_sh = r_data >> w_bit_nx;

   always_comb begin
      w_start = HDR;
      if (cmd_op == c_op_nop)
         w_start = IDLE;
      else if (cmd_op == c_op_rst || !r_synced)
         w_start = c_sync_state;

      w_len_acc = cmd_len;
      if (cmd_op == c_op_ir)
         w_len_acc = c_ir_len;
      else if (cmd_len == 6'd0)
         w_len_acc = 6'd1;
      else if (cmd_len > c_dr_max)
         w_len_acc = c_dr_max;

      case (r_state)
         RESET_SEQ: w_nbits = 6'd6;
         HDR:       w_nbits = r_ir ? 6'd4 : 6'd3;
         SHIFT:     w_nbits = r_len;
         default:   w_nbits = 6'd2;
      endcase
      w_last   = (r_bit == w_nbits - 6'd1);
      w_bit_nx = w_last ? 6'd0 : r_bit + 6'd1;

      w_state_nx = r_state;
      w_done     = 1'b0;
      if (w_accept) begin
         w_state_nx = w_start;
      end else if (w_fall && w_last) begin
         case (r_state)
`ifdef JTAG_SCAN_MASTER_TRST_EN
            TRST:      w_state_nx = RESET_SEQ;
`endif
            RESET_SEQ: begin
               w_state_nx = r_scan ? HDR : IDLE;
               w_done     = !r_scan;
            end
            HDR:       w_state_nx = SHIFT;
            SHIFT:     w_state_nx = TAIL;
            TAIL: begin
               w_state_nx = IDLE;
               w_done     = 1'b1;
            end
            default:   w_state_nx = IDLE;
         endcase
      end

      // tms/tdi for the bit that starts at this tclk fall
      case (w_state_nx)
`ifdef JTAG_SCAN_MASTER_TRST_EN
         TRST:      w_tms_nx = 1'b1;
`endif
         RESET_SEQ: w_tms_nx = (w_bit_nx != 6'd5);
         HDR:       w_tms_nx = r_ir ? (w_bit_nx < 6'd2) : (w_bit_nx == 6'd0);
         SHIFT:     w_tms_nx = (w_bit_nx == r_len - 6'd1);
         TAIL:      w_tms_nx = (w_bit_nx == 6'd0);
         default:   w_tms_nx = 1'b0;
      endcase
      w_tdi_nx = (w_state_nx == SHIFT) ? w_data_sh[0] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready   <= 1'b1;
         r_div     <= 8'd0;
         r_bit     <= 6'd0;
         r_len     <= 6'd0;
         r_ir      <= 1'b0;
         r_scan    <= 1'b0;
         r_synced  <= 1'b0;
         r_data    <= '0;
         r_cap     <= '0;
         r_tclk    <= 1'b0;
         r_tms     <= 1'b1;
         r_tdi     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (w_accept) begin
            r_ready <= 1'b0;
            r_div   <= 8'd0;
            r_bit   <= 6'd0;
            r_tclk  <= 1'b0;
            r_len   <= w_len_acc;
            r_ir    <= (cmd_op == c_op_ir);
            r_scan  <= (cmd_op == c_op_ir) || (cmd_op == c_op_dr);
            r_data  <= cmd_data;
            r_cap   <= '0;
            if (cmd_op == c_op_nop) begin
               rsp_valid <= 1'b1;
               rsp_data  <= '0;
            end else begin
               // every command opens with a tms=1 period
               r_tms <= 1'b1;
               r_tdi <= 1'b0;
            end
         end else if (r_state == IDLE) begin
            r_ready <= 1'b1;
         end else begin
            r_div <= w_tick ? 8'd0 : r_div + 8'd1;
            if (w_tick)
               r_tclk <= ~r_tclk;
            if (w_rise && r_state == SHIFT)
               r_cap[r_bit] <= tdo;
            if (w_fall) begin
               r_bit <= w_bit_nx;
               r_tms <= w_tms_nx;
               r_tdi <= w_tdi_nx;
            end
            if (w_fall && w_last && r_state == RESET_SEQ)
               r_synced <= 1'b1;
            if (w_done) begin
               rsp_valid <= 1'b1;
               rsp_data  <= r_cap;
            end
         end
      end
   end

`ifdef JTAG_SCAN_MASTER_TRST_EN
   logic r_trst_n;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_trst_n <= 1'b1;
      else
         r_trst_n <= (w_state_nx != TRST);
   end
   assign trst_n = r_trst_n;
`else
   assign trst_n = 1'b1;
`endif

endmodule

`default_nettype wire
